bus_sequencer: RTL and testbench
================================

BUS_SEQUENCER -- requirements
Module: bus_sequencer

Interface
REQ-001 Parameter NREG, 4, number of tristate registers on the shared 8-bit bus; power of two, 2..8.
REQ-002 Parameter NREQ, 4, number of transfer requesters; 2..8.
REQ-003 Derived SELW = clog2(NREG), the width of one register index.
REQ-004 Port clk  input  1  system clock; all state updates on rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port req  input  NREQ  per-requester transfer request; level, held until ack.
REQ-007 Port src  input  NREQ*SELW  packed source register index per requester (slice i = requester i).
REQ-008 Port dst  input  NREQ*SELW  packed destination register index per requester.
REQ-009 Port ack  output  NREQ  one-cycle completion pulse to the granted requester.
REQ-010 Port oc_n  output  NREG  active-low output control per register; drives the register onto the bus when 0.
REQ-011 Port load  output  NREG  load enable per register; latches bus on next clk edge.
REQ-012 Port busy  output  1  high while a transfer is in progress (state != IDLE).
REQ-013 Port err  output  1  one-cycle pulse on a suppressed (src == dst) transfer.

Function
REQ-014 All outputs SHALL be registered.
REQ-015 FSM states: IDLE, DRIVE, XFER, RELEASE.
REQ-016 IDLE: if any req bit set, select a winner round-robin starting at pointer rr_ptr, latch its src/dst/index, go to DRIVE; otherwise stay.
REQ-017 DRIVE: oc_n[src] = 0, all other oc_n = 1, load = 0; go to XFER (bus settle cycle).
REQ-018 XFER: oc_n[src] held 0, load[dst] = 1 for exactly one cycle; go to RELEASE.
REQ-019 RELEASE: oc_n all 1, load all 0, ack[winner] = 1 for one cycle, rr_ptr <= winner+1 mod NREQ; go to IDLE.
REQ-020 Latency: req sampled in IDLE at cycle N -> ack high at cycle N+3 (settle enabled); next grant no earlier than cycle N+4.
REQ-021 At most one oc_n bit SHALL be 0 in any cycle; at most one load bit SHALL be 1 in any cycle.
REQ-022 src == dst: no oc_n or load asserted; FSM goes IDLE -> RELEASE; ack and err pulse together.
REQ-023 Deasserting req mid-transfer SHALL NOT abort it; the transfer completes and ack still pulses.
REQ-024 Changes to src/dst after the grant SHALL be ignored until the next grant.
REQ-025 req held after its ack SHALL be treated as a new request, subject to round-robin order.

Reset
REQ-026 On reset assertion, immediately and asynchronously: oc_n = all 1, load = 0, ack = 0, err = 0, busy = 0, state = IDLE, rr_ptr = 0.
REQ-027 Reset mid-transfer abandons the transfer without ack; the requester must re-request.

Configuration
REQ-028 Macro BUS_SEQ_SETTLE_EN defined: DRIVE state present, 3-cycle grant-to-ack latency.
REQ-029 Macro BUS_SEQ_SETTLE_EN undefined: DRIVE omitted, IDLE -> XFER directly with oc_n[src] and load[dst] asserted in the same cycle, 2-cycle latency; all other rules unchanged.

Structure
REQ-030 Package bus_seq_pkg SHALL hold the state enum, NREG/NREQ defaults and the SELW/clog2 helper.
REQ-031 Sub-module rr_arbiter (NREQ-wide, request vector + pointer -> one-hot grant + index) SHALL implement winner selection.

Verification
REQ-032 Single transfer: req[0]=1, src0=2, dst0=1 at cycle 0 -> oc_n=4'b1011 at cycles 1-2, load=4'b0010 at cycle 2, ack=4'b0001 at cycle 3; register1 holds register2's value.
REQ-033 Round-robin: req=4'b1111 held -> ack order 0,1,2,3,0 at cycles 3,7,11,15,19.
REQ-034 Self-transfer: req[2]=1, src2=dst2=3 -> oc_n stays 4'b1111, load 0, ack[2] and err pulse at cycle 1.
REQ-035 Reset mid-XFER: reset=1 at cycle 2 -> oc_n=4'b1111 and load=0 before the next edge; no ack issued.
REQ-036 Drop request: req[1] deasserted in DRIVE -> transfer completes, ack[1] pulses at cycle 3.
REQ-037 Every cycle, assert popcount(~oc_n) <= 1 and popcount(load) <= 1 under random req/src/dst.

Source files
------------

// File: rtl/bus_sequencer_pkg.sv
// Shared types, default sizes and the width helper for the bus sequencer.
package bus_seq_pkg;

   localparam int NREG_DEFAULT = 4;
   localparam int NREQ_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DRIVE   = 2'd1,
      XFER    = 2'd2,
      RELEASE = 2'd3
   } seqState_t;

   // Never returns less than 1 so a two-entry index still gets a real bit.
   function automatic int clog2(input int n);
      int w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/bus_sequencer_if.sv
// Requester and tristate-bus control bundle between the sequencer and its users.
interface bus_seq_if
   import bus_seq_pkg::*;
#(
   parameter int NREG = NREG_DEFAULT,
   parameter int NREQ = NREQ_DEFAULT
);
   localparam int SELW = clog2(NREG);

   logic [NREQ-1:0]      req;
   logic [NREQ*SELW-1:0] src;
   logic [NREQ*SELW-1:0] dst;
   logic [NREQ-1:0]      ack;
   logic [NREG-1:0]      oc_n;
   logic [NREG-1:0]      load;
   logic                 busy;
   logic                 err;

   modport seq    (input req, src, dst, output ack, oc_n, load, busy, err);
   modport master (output req, src, dst, input ack, oc_n, load, busy, err);

endinterface

// File: rtl/bus_sequencer_rr_arbiter.sv
// Round-robin winner selection: first set request at or after the pointer, wrapping.
module rr_arbiter
   import bus_seq_pkg::*;
#(
   parameter  int NREQ = NREQ_DEFAULT,
   localparam int IDXW = clog2(NREQ)
)(
   input  logic [NREQ-1:0] i_req,
   input  logic [IDXW-1:0] i_ptr,
   output logic [NREQ-1:0] o_grant,
   output logic [IDXW-1:0] o_idx,
   output logic            o_valid
);

   always_comb begin
      int j;
      j       = 0;
      o_grant = '0;
      o_idx   = '0;
      o_valid = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         j = int'(i_ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!o_valid && i_req[j]) begin
            o_valid    = 1'b1;
            o_grant[j] = 1'b1;
            o_idx      = IDXW'(j);
         end
      end
   end

endmodule

// File: rtl/bus_sequencer.sv
// Moves a byte between tristate registers on a shared bus for round-robin requesters.
// Define BUS_SEQ_SETTLE_EN to insert a bus-settle cycle (DRIVE) before the load.
module bus_sequencer
   import bus_seq_pkg::*;
#(
   parameter int NREG = NREG_DEFAULT,
   parameter int NREQ = NREQ_DEFAULT
)(
   input logic   clk,
   input logic   reset,
   bus_seq_if.seq bus
);

   localparam int SELW = clog2(NREG);
   localparam int IDXW = clog2(NREQ);

   logic [NREQ-1:0] w_grant;
   logic [IDXW-1:0] w_grantIdx;
   logic            w_grantValid;
   logic [SELW-1:0] w_src;
   logic [SELW-1:0] w_dst;

   seqState_t       r_state;
   logic [IDXW-1:0] r_rrPtr;
   logic [IDXW-1:0] r_winner;
`ifdef BUS_SEQ_SETTLE_EN
   logic [SELW-1:0] r_dst;
`endif
   logic [NREG-1:0] r_ocN;
   logic [NREG-1:0] r_load;
   logic [NREQ-1:0] r_ack;
   logic            r_busy;
   logic            r_err;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .i_req   (bus.req),
      .i_ptr   (r_rrPtr),
      .o_grant (w_grant),
      .o_idx   (w_grantIdx),
      .o_valid (w_grantValid)
   );

   assign w_src = bus.src[w_grantIdx*SELW +: SELW];
   assign w_dst = bus.dst[w_grantIdx*SELW +: SELW];

   // Outputs are loaded alongside the state so each one reflects the state it is in.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_rrPtr  <= '0;
         r_winner <= '0;
`ifdef BUS_SEQ_SETTLE_EN
         r_dst    <= '0;
`endif
         r_ocN    <= '1;
         r_load   <= '0;
         r_ack    <= '0;
         r_busy   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_ack <= '0;
         r_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_grantValid) begin
                  r_winner <= w_grantIdx;
                  r_busy   <= 1'b1;
                  if (w_src == w_dst) begin
                     r_ack   <= w_grant;
                     r_err   <= 1'b1;
                     r_state <= RELEASE;
                  end else begin
                     r_ocN <= ~(NREG'(1) << w_src);
`ifdef BUS_SEQ_SETTLE_EN
                     r_dst   <= w_dst;
                     r_state <= DRIVE;
`else
                     r_load  <= NREG'(1) << w_dst;
                     r_state <= XFER;
`endif
                  end
               end
            end
`ifdef BUS_SEQ_SETTLE_EN
            DRIVE: begin
               r_load  <= NREG'(1) << r_dst;
               r_state <= XFER;
            end
`endif
            XFER: begin
               r_ocN   <= '1;
               r_load  <= '0;
               r_ack   <= NREQ'(1) << r_winner;
               r_state <= RELEASE;
            end
            RELEASE: begin
               r_busy  <= 1'b0;
               r_rrPtr <= (r_winner == IDXW'(NREQ - 1)) ? '0 : r_winner + 1'b1;
               r_state <= IDLE;
            end
            default: begin
               r_ocN   <= '1;
               r_load  <= '0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.ack  = r_ack;
   assign bus.oc_n = r_ocN;
   assign bus.load = r_load;
   assign bus.busy = r_busy;
   assign bus.err  = r_err;

endmodule

// File: tb/tb_bus_sequencer.sv
// Bench for bus_sequencer: directed scenarios plus random traffic against a phase-level model.
module tb_bus_sequencer;

   localparam int NREG = 4;
   localparam int NREQ = 4;
   localparam int SELW = 2;
`ifdef BUS_SEQ_SETTLE_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif
   localparam logic [13:0] IDLE_VEC = 14'b0000_1111_0000_0_0;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   total = 0;
   int   bad   = 0;

   bus_seq_if #(.NREG(NREG), .NREQ(NREQ)) bus ();

   bus_sequencer #(.NREG(NREG), .NREQ(NREQ)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Emulated tristate registers: the register with oc_n low drives the bus, load latches it.
   logic [7:0] physReg  [NREG] = '{8'h11, 8'h22, 8'h33, 8'h44};
   logic [7:0] modelReg [NREG] = '{8'h11, 8'h22, 8'h33, 8'h44};
   logic [7:0] busData;

   always_comb begin
      busData = 8'h00;
      for (int k = 0; k < NREG; k++)
         if (bus.oc_n[k] === 1'b0) busData = physReg[k];
   end

   always @(posedge clk)
      for (int k = 0; k < NREG; k++)
         if (bus.load[k] === 1'b1) physReg[k] <= busData;

   // Reference model: a transfer is a grant edge plus a phase count, nothing finer.
   int         edgeCnt = 0;
   bit         mActive = 1'b0;
   bit         mSelf   = 1'b0;
   int         mGrant  = 0;
   int         mLat    = 0;
   int         mWinner = 0;
   int         mPtr    = 0;
   int         mSrc    = 0;
   int         mDst    = 0;
   logic [3:0] expAck, expOcN, expLoad;
   logic       expBusy, expErr;

   function automatic logic [13:0] expVec();
      return {expAck, expOcN, expLoad, expBusy, expErr};
   endfunction

   function automatic logic [13:0] obsVec();
      return {bus.ack, bus.oc_n, bus.load, bus.busy, bus.err};
   endfunction

   task automatic stepCycle();
      int d;
      @(posedge clk);
      edgeCnt++;
      if (reset) begin
         mActive = 1'b0;
         mPtr    = 0;
      end else begin
         if (mActive && (edgeCnt - mGrant) > mLat) mActive = 1'b0;
         if (!mActive && bus.req != '0) begin
            for (int k = 0; k < NREQ; k++) begin
               int i = (mPtr + k) % NREQ;
               if (bus.req[i]) begin
                  mWinner = i;
                  break;
               end
            end
            mSrc    = int'(bus.src[mWinner*SELW +: SELW]);
            mDst    = int'(bus.dst[mWinner*SELW +: SELW]);
            mSelf   = (mSrc == mDst);
            mLat    = mSelf ? 1 : LAT;
            mGrant  = edgeCnt;
            mActive = 1'b1;
            mPtr    = (mWinner + 1) % NREQ;
         end
      end
      expAck = '0; expOcN = '1; expLoad = '0; expBusy = 1'b0; expErr = 1'b0;
      if (mActive) begin
         d = edgeCnt - mGrant;
         expBusy = (d < mLat);
         if (d == mLat - 1) begin
            expAck[mWinner] = 1'b1;
            expErr = mSelf;
            if (!mSelf) modelReg[mDst] = modelReg[mSrc];
         end
         if (!mSelf && d < mLat - 1)  expOcN[mSrc]  = 1'b0;
         if (!mSelf && d == mLat - 2) expLoad[mDst] = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic setReq(input int i, input bit on, input int s, input int d);
      bus.req[i]              = on;
      bus.src[i*SELW +: SELW] = SELW'(s);
      bus.dst[i*SELW +: SELW] = SELW'(d);
   endtask

   task automatic test_reset();
      #2 reset = 1'b1;
      #1;
      total++;
      if (obsVec() !== IDLE_VEC) begin
         bad++;
         $display("[TB] FAIL reset_async got=%b exp=%b", obsVec(), IDLE_VEC);
      end
      repeat (2) begin
         stepCycle();
         total++;
         if (obsVec() !== expVec()) begin
            bad++;
            $display("[TB] FAIL reset_hold got=%b exp=%b", obsVec(), expVec());
         end
      end
      reset = 1'b0;
      repeat (2) begin
         stepCycle();
         total++;
         if (obsVec() !== IDLE_VEC) begin
            bad++;
            $display("[TB] FAIL reset_idle got=%b exp=%b", obsVec(), IDLE_VEC);
         end
      end
   endtask

   task automatic test_single();
      setReq(0, 1'b1, 2, 1);
      for (int s = 1; s <= LAT + 1; s++) begin
         stepCycle();
         total++;
         if (obsVec() !== expVec()) begin
            bad++;
            $display("[TB] FAIL single_vec cyc=%0d got=%b exp=%b", s, obsVec(), expVec());
         end
         if (s == LAT) begin
            total++;
            if (bus.ack !== 4'b0001) begin
               bad++;
               $display("[TB] FAIL single_ack_latency got=%b exp=0001", bus.ack);
            end
         end
         if (expAck[0]) bus.req[0] = 1'b0;
      end
      total++;
      if (physReg[1] !== 8'h33) begin
         bad++;
         $display("[TB] FAIL single_data got=%h exp=33", physReg[1]);
      end
   endtask

   task automatic test_self();
      setReq(2, 1'b1, 3, 3);
      for (int s = 1; s <= 3; s++) begin
         stepCycle();
         total++;
         if (obsVec() !== expVec()) begin
            bad++;
            $display("[TB] FAIL self_vec cyc=%0d got=%b exp=%b", s, obsVec(), expVec());
         end
         if (s == 1) begin
            total++;
            if ({bus.ack, bus.err, bus.oc_n, bus.load} !== {4'b0100, 1'b1, 4'b1111, 4'b0000}) begin
               bad++;
               $display("[TB] FAIL self_pulse got ack=%b err=%b oc_n=%b load=%b exp ack=0100 err=1 oc_n=1111 load=0000",
                        bus.ack, bus.err, bus.oc_n, bus.load);
            end
         end
         if (expAck[2]) bus.req[2] = 1'b0;
      end
      total++;
      if (physReg[3] !== 8'h44) begin
         bad++;
         $display("[TB] FAIL self_data got=%h exp=44", physReg[3]);
      end
   endtask

   task automatic test_drop();
      setReq(1, 1'b1, 3, 0);
      for (int s = 1; s <= LAT + 1; s++) begin
         stepCycle();
         if (s == 1) bus.req[1] = 1'b0;
         total++;
         if (obsVec() !== expVec()) begin
            bad++;
            $display("[TB] FAIL drop_vec cyc=%0d got=%b exp=%b", s, obsVec(), expVec());
         end
         if (s == LAT) begin
            total++;
            if (bus.ack !== 4'b0010) begin
               bad++;
               $display("[TB] FAIL drop_ack got=%b exp=0010", bus.ack);
            end
         end
      end
      total++;
      if (physReg[0] !== 8'h44) begin
         bad++;
         $display("[TB] FAIL drop_data got=%h exp=44", physReg[0]);
      end
   endtask

   task automatic test_reset_mid();
      int budget = 4;
      setReq(3, 1'b1, 0, 2);
      do begin
         stepCycle();
         budget--;
         total++;
         if (obsVec() !== expVec()) begin
            bad++;
            $display("[TB] FAIL rstmid_vec got=%b exp=%b", obsVec(), expVec());
         end
      end while (expLoad == '0 && budget > 0);
      if (expLoad == '0) begin
         total++;
         bad++;
         $display("[TB] FAIL rstmid_reach_xfer got=none exp=load phase");
      end
      reset      = 1'b1;
      bus.req[3] = 1'b0;
      #1;
      total++;
      if (obsVec() !== IDLE_VEC) begin
         bad++;
         $display("[TB] FAIL rstmid_async got=%b exp=%b", obsVec(), IDLE_VEC);
      end
      repeat (2) begin
         stepCycle();
         total++;
         if (obsVec() !== expVec()) begin
            bad++;
            $display("[TB] FAIL rstmid_hold got=%b exp=%b", obsVec(), expVec());
         end
      end
      reset = 1'b0;
      repeat (2) begin
         stepCycle();
         total++;
         if (obsVec() !== IDLE_VEC) begin
            bad++;
            $display("[TB] FAIL rstmid_noack got=%b exp=%b", obsVec(), IDLE_VEC);
         end
      end
      total++;
      if (physReg[2] !== 8'h33) begin
         bad++;
         $display("[TB] FAIL rstmid_data got=%h exp=33", physReg[2]);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] rrExp;
      for (int i = 0; i < NREQ; i++) setReq(i, 1'b1, i, (i + 1) % NREQ);
      for (int s = 1; s <= 5 * (LAT + 1); s++) begin
         stepCycle();
         total++;
         if (obsVec() !== expVec()) begin
            bad++;
            $display("[TB] FAIL rr_vec cyc=%0d got=%b exp=%b", s, obsVec(), expVec());
         end
         if (s >= LAT && (s - LAT) % (LAT + 1) == 0)
            rrExp = 4'(1 << (((s - LAT) / (LAT + 1)) % NREQ));
         else
            rrExp = '0;
         total++;
         if (bus.ack !== rrExp) begin
            bad++;
            $display("[TB] FAIL rr_order cyc=%0d got=%b exp=%b", s, bus.ack, rrExp);
         end
      end
      bus.req = '0;
      repeat (LAT + 2) begin
         stepCycle();
         total++;
         if (obsVec() !== expVec()) begin
            bad++;
            $display("[TB] FAIL rr_drain got=%b exp=%b", obsVec(), expVec());
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         stepCycle();
         total++;
         if (obsVec() !== expVec()) begin
            bad++;
            $display("[TB] FAIL rand_vec cyc=%0d got=%b exp=%b", c, obsVec(), expVec());
         end
         total++;
         if ($countones(~bus.oc_n) > 1 || $countones(bus.load) > 1) begin
            bad++;
            $display("[TB] FAIL rand_onehot cyc=%0d oc_n=%b load=%b exp at most one active each", c, bus.oc_n, bus.load);
         end
         for (int i = 0; i < NREQ; i++) begin
            if (bus.req[i]) begin
               if (expAck[i]) begin
                  if ($urandom_range(1, 0) == 0) bus.req[i] = 1'b0;
                  else setReq(i, 1'b1, $urandom_range(3, 0), $urandom_range(3, 0));
               end else if (mActive && i == mWinner && (edgeCnt - mGrant) < mLat - 1 &&
                            $urandom_range(7, 0) == 0) begin
                  bus.req[i] = 1'b0;
               end
            end else if ($urandom_range(3, 0) == 0) begin
               setReq(i, 1'b1, $urandom_range(3, 0), $urandom_range(3, 0));
            end
            if ($urandom_range(7, 0) == 0)
               setReq(i, bus.req[i], $urandom_range(3, 0), $urandom_range(3, 0));
         end
      end
      bus.req = '0;
      repeat (LAT + 2) begin
         stepCycle();
         total++;
         if (obsVec() !== expVec()) begin
            bad++;
            $display("[TB] FAIL rand_drain got=%b exp=%b", obsVec(), expVec());
         end
      end
      for (int k = 0; k < NREG; k++) begin
         total++;
         if (physReg[k] !== modelReg[k]) begin
            bad++;
            $display("[TB] FAIL rand_data reg%0d got=%h exp=%h", k, physReg[k], modelReg[k]);
         end
      end
   endtask

   initial begin
      bus.req = '0;
      bus.src = '0;
      bus.dst = '0;
      test_reset();
      test_single();
      test_self();
      test_drop();
      test_reset_mid();
      test_round_robin();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog time limit reached got=running exp=finished");
      $fatal(1, "[TB] watchdog");
   end

endmodule
